// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: merges two valid/ready streams (B, C) onto one
// registered output line. It uses round-robin arbitration between packets,
// and once a packet starts, its source keeps the grant until its last beat.
//
// Handshake: a beat moves across any interface on a rising edge where
// valid and ready are both high. Valid never waits for ready. On the
// outputs, a ready may be high while the matching valid is low; no beat
// moves in that case. At most one input ready is high in any cycle.
module mux2_stream_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inB_data,
  input  logic             inB_valid,
  input  logic             inB_last,
  output logic             inB_ready,
  input  logic [WIDTH-1:0] inC_data,
  input  logic             inC_valid,
  input  logic             inC_last,
  output logic             inC_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_B = 2'd1,
    LOCK_C = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   prio, prio_nx;   // 0 = B goes first on a tie, 1 = C
  logic   grant_b, grant_c;
  logic   load_en;
  logic   accept_b, accept_c;

  assign state_dbg = state;

  // Grant selection, input readies and next-state / priority update.
  always_comb begin
    grant_b   = 1'b0;
    grant_c   = 1'b0;
    state_nx  = state;
    prio_nx   = prio;
    load_en   = ~out_valid | out_ready;
    case (state)
      IDLE: begin
        if (inB_valid && inC_valid) begin
          grant_b = ~prio;
          grant_c = prio;
        end else begin
          grant_b = inB_valid;
          grant_c = inC_valid;
        end
      end
      LOCK_B:  grant_b = 1'b1;
      LOCK_C:  grant_c = 1'b1;
      default: ;
    endcase
    // rst_n gates the readies so nothing is acknowledged while held in reset.
    inB_ready = load_en & grant_b & rst_n;
    inC_ready = load_en & grant_c & rst_n;
    accept_b  = inB_ready & inB_valid;
    accept_c  = inC_ready & inC_valid;
    // A last beat closes the packet and hands priority to the other line.
    if (accept_b) begin
      if (inB_last) begin
        state_nx = IDLE;
        prio_nx  = 1'b1;
      end else begin
        state_nx = LOCK_B;
      end
    end else if (accept_c) begin
      if (inC_last) begin
        state_nx = IDLE;
        prio_nx  = 1'b0;
      end else begin
        state_nx = LOCK_C;
      end
    end
  end

  // Arbitration state and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nx;
      prio  <= prio_nx;
    end
  end

  // Output slot: load on an accepted beat, otherwise drain when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept_b || accept_c) begin
      out_valid <= 1'b1;
      out_data  <= accept_c ? inC_data : inB_data;
      out_last  <= accept_c ? inC_last : inB_last;
      out_sel   <= accept_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Testbench for mux2_stream_arbiter: directed scenarios followed by a
// randomized run against a packet-level reference model.
module tb_mux2_stream_arbiter;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] inB_data, inC_data;
  logic         inB_valid, inB_last, inB_ready;
  logic         inC_valid, inC_last, inC_ready;
  logic [W-1:0] out_data;
  logic         out_sel, out_last, out_valid, out_ready;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: beats accepted but not yet consumed, as {sel, last, data}
  logic [W+1:0] exp_q[$];

  // reference model state
  bit           in_pkt;
  bit           pkt_src;
  bit           rr_next;
  int           left   [2];
  logic [W-1:0] cur_data [2];
  logic         cur_last [2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mux2_stream_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inB_data(inB_data), .inB_valid(inB_valid), .inB_last(inB_last), .inB_ready(inB_ready),
    .inC_data(inC_data), .inC_valid(inC_valid), .inC_last(inC_last), .inC_ready(inC_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inB_valid = 1'b0; inB_data = '0; inB_last = 1'b0;
    inC_valid = 1'b0; inC_data = '0; inC_last = 1'b0;
  endtask

  // Hold reset with both lines valid: readies must stay low, outputs zero.
  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    inB_valid = 1'b1; inC_valid = 1'b1; inB_last = 1'b1; inC_last = 1'b1;
    out_ready = 1'b1;
    step();
    check("rst_b_ready", 32'(inB_ready), 0);
    check("rst_c_ready", 32'(inC_ready), 0);
    check("rst_valid",   32'(out_valid), 0);
    check("rst_data",    32'(out_data),  0);
    check("rst_sel",     32'(out_sel),   0);
    check("rst_last",    32'(out_last),  0);
    idle_inputs();
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- random driver helpers ----------------
  task automatic new_beat(input int s);
    if (left[s] == 0) left[s] = $urandom_range(1, 4);
    cur_data[s] = W'($urandom);
    left[s]--;
    cur_last[s] = (left[s] == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit           vb, vc, le, acc_b, acc_c;
    int           g;
    logic [W+1:0] head;

    idle_inputs();
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // single B beat passes straight through
    reset_dut();
    inB_valid = 1'b1; inB_data = 2'b10; inB_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t1_b_ready", 32'(inB_ready), 1);
    check("t1_c_ready", 32'(inC_ready), 0);
    step();
    inB_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data",  32'(out_data),  2);
    check("t1_sel",   32'(out_sel),   0);
    check("t1_last",  32'(out_last),  1);

    // both lines streaming single-beat packets alternate every cycle
    reset_dut();
    inB_valid = 1'b1; inB_data = 2'b01; inB_last = 1'b1;
    inC_valid = 1'b1; inC_data = 2'b11; inC_last = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_valid", 32'(out_valid), 1);
      check("t2_sel",   32'(out_sel),   32'(i % 2));
      check("t2_data",  32'(out_data),  (i % 2) ? 3 : 1);
    end
    idle_inputs();

    // packet lock: three-beat B packet keeps C blocked
    reset_dut();
    out_ready = 1'b1;
    inC_valid = 1'b1; inC_data = 2'b11; inC_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inB_valid = 1'b1; inB_data = W'(i); inB_last = (i == 2);
      @(negedge clk);
      check("t3_c_blocked", 32'(inC_ready), 0);
      check("t3_b_ready",   32'(inB_ready), 1);
      step();
      check("t3_data", 32'(out_data), 32'(i));
      check("t3_sel",  32'(out_sel),  0);
    end
    inB_valid = 1'b0;
    @(negedge clk);
    check("t3_c_granted", 32'(inC_ready), 1);
    step();
    check("t3_c_sel",  32'(out_sel),  1);
    check("t3_c_data", 32'(out_data), 3);
    idle_inputs();

    // back-pressure holds the first beat, then beats follow in order
    reset_dut();
    inB_valid = 1'b1; inB_data = 2'd1; inB_last = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("t4_first_ready", 32'(inB_ready), 1);
    step();
    inB_data = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(inB_ready), 0);
      check("t4_hold_valid",  32'(out_valid), 1);
      check("t4_hold_data",   32'(out_data),  1);
      check("t4_hold_sel",    32'(out_sel),   0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_resume_ready", 32'(inB_ready), 1);
    step();
    check("t4_beat2", 32'(out_data), 2);
    inB_data = 2'd3;
    step();
    check("t4_beat3", 32'(out_data), 3);
    inB_valid = 1'b0;
    step();
    check("t4_drained", 32'(out_valid), 0);

    // async reset while C holds the lock
    reset_dut();
    out_ready = 1'b1;
    inC_valid = 1'b1; inC_data = 2'd2; inC_last = 1'b0;
    step();
    inC_valid = 1'b0;
    inB_valid = 1'b1; inB_data = 2'd1; inB_last = 1'b1;
    check("t5_c_loaded", 32'(out_sel), 1);
    @(negedge clk);
    check("t5_b_blocked", 32'(inB_ready), 0);
    check("t5_c_held",    32'(inC_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",   32'(out_valid), 0);
    check("t5_rst_b_ready", 32'(inB_ready), 0);
    check("t5_rst_c_ready", 32'(inC_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    inC_valid = 1'b1; inC_data = 2'd3; inC_last = 1'b1;
    #1;
    check("t5_b_first",  32'(inB_ready), 1);
    check("t5_c_waits",  32'(inC_ready), 0);
    step();
    check("t5_sel", 32'(out_sel),  0);
    check("t5_data", 32'(out_data), 1);
    idle_inputs();

    // nothing valid: no grant, nothing appears
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_b_ready", 32'(inB_ready), 0);
      check("t6_c_ready", 32'(inC_ready), 0);
      step();
      check("t6_valid", 32'(out_valid), 0);
    end

    // randomized run against the packet-level model
    reset_dut();
    exp_q.delete();
    in_pkt = 0; pkt_src = 0; rr_next = 0;
    left[0] = 0; left[1] = 0;
    new_beat(0);
    new_beat(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      inB_valid = ($urandom_range(0, 9) < 7);
      inB_data  = cur_data[0]; inB_last = cur_last[0];
      inC_valid = ($urandom_range(0, 9) < 7);
      inC_data  = cur_data[1]; inC_last = cur_last[1];
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      vb = inB_valid; vc = inC_valid;
      if (in_pkt)        g = int'(pkt_src);
      else if (vb && vc) g = int'(rr_next);
      else if (vb)       g = 0;
      else if (vc)       g = 1;
      else               g = 2;
      le = (exp_q.size() == 0) || out_ready;
      check("rnd_b_ready", 32'(inB_ready), 32'(le && g == 0));
      check("rnd_c_ready", 32'(inC_ready), 32'(le && g == 1));
      check("rnd_valid",   32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("rnd_beat", 32'({out_sel, out_last, out_data}), 32'(head));
        if (out_ready) void'(exp_q.pop_front());
      end
      acc_b = le && g == 0 && vb;
      acc_c = le && g == 1 && vc;
      if (acc_b || acc_c) begin
        if (acc_b) exp_q.push_back({1'b0, cur_last[0], cur_data[0]});
        else       exp_q.push_back({1'b1, cur_last[1], cur_data[1]});
        if (cur_last[g]) begin
          in_pkt  = 0;
          rr_next = (g == 0);
        end else begin
          in_pkt  = 1;
          pkt_src = (g == 1);
        end
        new_beat(g);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-to-one stream multiplexer with round-robin arbitration and packet locking. It is the merging counterpart of the 1-to-2 demultiplexer: two source lines B and C, each with a valid/ready handshake, are combined onto one registered output line. The output carries a select tag identifying the source (0 = B, 1 = C), using the same select encoding as the demultiplexer. The block sits upstream of any single-lane consumer that is fed by two producers.

## Interface
- WIDTH, 2: data width of every line.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inB_data  in  WIDTH  line B data.
- inB_valid  in  1  line B beat present.
- inB_last  in  1  final beat of a line-B packet.
- inB_ready  out  1  line B beat accepted this cycle when high together with inB_valid.
- inC_data, inC_valid, inC_last, inC_ready: same as the four line-B ports, for line C.
- out_data  out  WIDTH  registered merged data.
- out_sel  out  1  source of the current beat: 0 = B, 1 = C.
- out_last  out  1  registered copy of the accepted beat's last flag.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the beat when high together with out_valid.

## Operation
- Output register slot:
  - load_en = ~out_valid | out_ready.
  - The slot loads when a granted input beat is accepted.
  - It clears out_valid when out_ready is high and no new beat is loaded.
- Handshake rules:
  - inB_ready = load_en & grant_B.
  - inC_ready = load_en & grant_C.
  - The grant is combinational within the cycle.
  - At most one input ready is ever high.
  - A ready may be high while the matching valid is low; no transfer occurs in that case.
- State machine:
  - States: IDLE, LOCK_B, LOCK_C.
  - IDLE:
    - Only B valid: grant B. Only C valid: grant C.
    - Both valid: grant the source indicated by the priority pointer `prio`, where 0 = B and 1 = C.
    - Neither valid: no grant.
  - Accepting a beat in IDLE:
    - Beat with last = 0: go to LOCK_B or LOCK_C, whichever matches the source.
    - Beat with last = 1: stay in IDLE and set prio to the other source.
  - LOCK_B:
    - Grant B only; inC_ready = 0 regardless of inC_valid.
    - On acceptance of a B beat with last = 1: go to IDLE and set prio = 1.
  - LOCK_C: symmetric to LOCK_B; on acceptance of a C beat with last = 1, go to IDLE and set prio = 0.
- On load, the slot captures the granted line's data and last flag, and out_sel is set to the granted source.
- Data is never modified, dropped or duplicated. Beats of one packet are never interleaved with beats from the other line.

## Timing
- Latency: a beat accepted at edge N appears on the outputs from edge N through to the edge where out_ready is high.
- Throughput: one beat per cycle while out_ready is held high.
- Back-pressure:
  - With out_valid = 1 and out_ready = 0, both input readies are 0.
  - The out_data, out_sel and out_last outputs are held stable.
- Values held while rst_n is low, and immediately after reset:
  - out_valid = 0, out_data = 0, out_sel = 0, out_last = 0.
  - State = IDLE, prio = 0.
  - inB_ready = inC_ready = 0, forced low while rst_n is low.
- Reset mid-packet:
  - The lock is abandoned and the slot contents are discarded.
  - The first post-reset grant follows IDLE rules with prio = 0.
- Simultaneous events in one cycle: an out_ready drain and a new load are allowed together; the new beat replaces the old one with no bubble.
- Input valid withdrawn mid-packet:
  - The lock is held and the other line stays blocked.
  - The block waits indefinitely; there is no timeout.
- A last flag on a beat while the slot is stalled takes effect only when that beat is accepted.

## Test plan
- Reset, then inB_valid = 1, inB_data = 2'b10, inB_last = 1, out_ready = 1:
  - inB_ready = 1 in that cycle.
  - Next cycle: out_valid = 1, out_data = 2'b10, out_sel = 0, out_last = 1.
- Both lines valid with single-beat packets continuously (B = 2'b01, C = 2'b11), out_ready = 1: out_sel sequence is 0,1,0,1,…, with one beat per cycle.
- Packet lock:
  - Stimulus: B sends three beats 00,01,10 with last on the third; C is valid throughout.
  - Required: inC_ready stays 0 for those three beats, then C is granted on the next cycle.
- Back-pressure: out_ready = 0 for 4 cycles while B is valid.
  - Outputs hold the first beat; inB_ready = 0.
  - After out_ready rises, beats arrive in order with none lost.
- Reset mid-packet:
  - Stimulus: assert rst_n = 0 asynchronously during LOCK_C.
  - Required: out_valid drops immediately; after release, B is granted first when both lines are valid.
- Idle ready: no input valid and out_valid = 0, so the grant is none and out_valid stays 0.
